// File: rtl/f_npc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// f_npc_ctrl_pkg
// Shared constants and encodings for the fetch-stage next-PC logic.
//   PC_RESET    : fetch address loaded by reset
//   EXC_VECTOR  : exception / interrupt entry point
//   IM_LO/IM_HI : first and last legal word address of instruction memory
//   npc_op_e    : D-stage transfer kinds (codes 4-7 behave as NPC_SEQ)
//   fetch_addr_err() : alignment / range check used for F_AdEL
// ---------------------------------------------------------------------------
package f_npc_ctrl_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'd0,
        NPC_BR  = 3'd1,
        NPC_J   = 3'd2,
        NPC_JR  = 3'd3
    } npc_op_e;

    function automatic logic fetch_addr_err(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    endfunction

endpackage

// File: rtl/f_npc_calc.sv
// ---------------------------------------------------------------------------
// f_npc_calc
// Combinational target computation for the D-stage transfer kind.
// Ports:
//   pc        in  32  current fetch address (sequential successor base)
//   npc_op    in   3  transfer kind (NPC_SEQ/NPC_BR/NPC_J/NPC_JR, 4-7 = SEQ)
//   br_taken  in   1  branch-compare result
//   D_PC      in  32  PC of the instruction in D
//   D_imm16   in  16  branch offset field
//   D_imm26   in  26  jump index field
//   D_Rs      in  32  jr target
//   target    out 32  address to fetch next when no higher-priority event
// ---------------------------------------------------------------------------
module f_npc_calc
    import f_npc_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_Rs,
    output logic [31:0] target
);

    // Word offset, sign-extended and scaled to bytes.
    logic signed [31:0] br_off;
    logic        [31:0] seq_target;
    logic        [31:0] br_target;

    assign br_off     = {{14{D_imm16[15]}}, D_imm16, 2'b00};
    // Both additions wrap modulo 2^32; overflow is not a fault here.
    assign seq_target = pc + 32'd4;
    assign br_target  = D_PC + 32'd4 + $unsigned(br_off);

    always_comb begin
        target = seq_target;
        case (npc_op)
            NPC_BR:  target = br_taken ? br_target : seq_target;
            NPC_J:   target = {D_PC[31:28], D_imm26, 2'b00};
            NPC_JR:  target = D_Rs;
            default: target = seq_target;
        endcase
    end

endmodule

// File: rtl/f_npc_ctrl.sv
// ---------------------------------------------------------------------------
// f_npc_ctrl
// Fetch-stage PC register with next-PC priority selection.
// Priority: exc_req > (eret & ~stall) > stall > npc_op target.
// Ports:
//   clk       in   1  clock, rising edge
//   reset     in   1  synchronous, active-low
//   stall     in   1  hold F_PC
//   npc_op    in   3  D-stage transfer kind
//   br_taken  in   1  branch-compare result
//   D_PC      in  32  PC of the D instruction
//   D_imm16   in  16  branch offset
//   D_imm26   in  26  jump index
//   D_Rs      in  32  jr target
//   exc_req   in   1  exception / interrupt taken
//   eret      in   1  eret in D (ignored while stalled)
//   EPC       in  32  eret return address
//   F_PC      out 32  fetch address register
//   F_BD      out  1  F instruction sits in a delay slot
//   F_AdEL    out  1  fetch address error for F_PC
//   F_flush   out  1  registered pulse marking the F instruction as a bubble
// ---------------------------------------------------------------------------
module f_npc_ctrl
    import f_npc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_Rs,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] EPC,
    output logic [31:0] F_PC,
    output logic        F_BD,
    output logic        F_AdEL,
    output logic        F_flush
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] calc_target;
    logic        flush_q;
    logic        flush_next;

    f_npc_calc u_calc (
        .pc       (pc_q),
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .D_PC     (D_PC),
        .D_imm16  (D_imm16),
        .D_imm26  (D_imm26),
        .D_Rs     (D_Rs),
        .target   (calc_target)
    );

    always_comb begin
        pc_next    = calc_target;
        flush_next = 1'b0;
        if (exc_req) begin
            pc_next    = EXC_VECTOR;
            flush_next = 1'b1;
        end else if (eret && !stall) begin
            pc_next    = EPC;
            flush_next = 1'b1;
        end else if (stall) begin
            pc_next    = pc_q;
        end
    end

    // Misaligned or out-of-range targets are still loaded; F_AdEL reports them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= PC_RESET;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_next;
            flush_q <= flush_next;
        end
    end

    assign F_PC    = pc_q;
    assign F_flush = flush_q;
    assign F_AdEL  = fetch_addr_err(pc_q);
    assign F_BD    = (npc_op == NPC_BR) || (npc_op == NPC_J) || (npc_op == NPC_JR);

endmodule

// File: tb/tb_f_npc_ctrl.sv
module tb_f_npc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_op;
    logic        br_taken;
    logic [31:0] D_PC;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;
    logic [31:0] D_Rs;
    logic        exc_req;
    logic        eret;
    logic [31:0] EPC;
    logic [31:0] F_PC;
    logic        F_BD;
    logic        F_AdEL;
    logic        F_flush;

    int vectors = 0;
    int errors  = 0;

    // reference state
    logic [31:0] m_pc    = 32'h0000_3000;
    logic        m_flush = 1'b0;

    always #5 clk = ~clk;

    f_npc_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .D_PC     (D_PC),
        .D_imm16  (D_imm16),
        .D_imm26  (D_imm26),
        .D_Rs     (D_Rs),
        .exc_req  (exc_req),
        .eret     (eret),
        .EPC      (EPC),
        .F_PC     (F_PC),
        .F_BD     (F_BD),
        .F_AdEL   (F_AdEL),
        .F_flush  (F_flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic logic model_adel(input logic [31:0] pc);
        int unsigned a;
        a = pc;
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    // Next fetch address from the rules, in plain arithmetic.
    function automatic logic [31:0] model_target(input logic [31:0] pc);
        int          off;
        logic [31:0] t;
        case (npc_op)
            3'd1: begin
                if (br_taken) begin
                    off = int'($signed(D_imm16)) * 4;
                    t   = D_PC + 32'd4 + 32'(off);
                end else begin
                    t = pc + 32'd4;
                end
            end
            3'd2:    t = (D_PC & 32'hF000_0000) + (32'(D_imm26) * 4);
            3'd3:    t = D_Rs;
            default: t = pc + 32'd4;
        endcase
        return t;
    endfunction

    // One clock: check combinational F_BD, advance the model, compare outputs.
    task automatic cycle();
        logic [31:0] n_pc;
        logic        n_flush;
        #1;
        chk("F_BD", {31'd0, F_BD}, {31'd0, (npc_op >= 3'd1 && npc_op <= 3'd3)});
        if (!reset) begin
            n_pc = 32'h0000_3000; n_flush = 1'b0;
        end else if (exc_req) begin
            n_pc = 32'h0000_4180; n_flush = 1'b1;
        end else if (eret && !stall) begin
            n_pc = EPC; n_flush = 1'b1;
        end else if (stall) begin
            n_pc = m_pc; n_flush = 1'b0;
        end else begin
            n_pc = model_target(m_pc); n_flush = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pc    = n_pc;
        m_flush = n_flush;
        chk("F_PC", F_PC, m_pc);
        chk("F_flush", {31'd0, F_flush}, {31'd0, m_flush});
        chk("F_AdEL", {31'd0, F_AdEL}, {31'd0, model_adel(m_pc)});
    endtask

    task automatic idle();
        reset = 1'b1; stall = 1'b0; npc_op = 3'd0; br_taken = 1'b0;
        D_PC = 32'h0; D_imm16 = 16'h0; D_imm26 = 26'h0; D_Rs = 32'h0;
        exc_req = 1'b0; eret = 1'b0; EPC = 32'h0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(negedge clk);
        cycle();
        chk("reset_pc", F_PC, 32'h0000_3000);
        chk("reset_flush", {31'd0, F_flush}, 32'd0);
        chk("reset_adel", {31'd0, F_AdEL}, 32'd0);

        // sequential run
        idle();
        cycle(); chk("seq1", F_PC, 32'h0000_3004);
        cycle(); chk("seq2", F_PC, 32'h0000_3008);
        cycle(); chk("seq3", F_PC, 32'h0000_300C);

        // taken branch with negative offset
        npc_op = 3'd1; br_taken = 1'b1; D_PC = 32'h3010; D_imm16 = 16'hFFFC;
        #1 chk("br_bd", {31'd0, F_BD}, 32'd1);
        cycle(); chk("br_taken", F_PC, 32'h0000_3004);
        // reach 0x3014 via jr, then untaken branch
        idle(); npc_op = 3'd3; D_Rs = 32'h3014;
        cycle(); chk("jr_3014", F_PC, 32'h0000_3014);
        idle(); npc_op = 3'd1; br_taken = 1'b0; D_PC = 32'h3010; D_imm16 = 16'hFFFC;
        cycle(); chk("br_not_taken", F_PC, 32'h0000_3018);

        // exception wins over stall and jump
        idle(); stall = 1'b1; npc_op = 3'd2; exc_req = 1'b1; D_imm26 = 26'h0000_C00;
        cycle(); chk("exc_pc", F_PC, 32'h0000_4180);
        chk("exc_flush", {31'd0, F_flush}, 32'd1);
        idle();
        cycle(); chk("exc_flush_end", {31'd0, F_flush}, 32'd0);
        chk("after_exc", F_PC, 32'h0000_4184);

        // eret ignored while stalled, honoured once released
        idle(); eret = 1'b1; EPC = 32'h3020; stall = 1'b1;
        cycle(); chk("eret_stalled", F_PC, 32'h0000_4184);
        chk("eret_stalled_fl", {31'd0, F_flush}, 32'd0);
        stall = 1'b0;
        cycle(); chk("eret_pc", F_PC, 32'h0000_3020);
        chk("eret_flush", {31'd0, F_flush}, 32'd1);
        idle();
        cycle(); chk("eret_flush_end", {31'd0, F_flush}, 32'd0);

        // jr address errors
        idle(); npc_op = 3'd3; D_Rs = 32'h3002;
        cycle(); chk("jr_mis_pc", F_PC, 32'h0000_3002);
        chk("jr_mis_adel", {31'd0, F_AdEL}, 32'd1);
        D_Rs = 32'h7000;
        cycle(); chk("jr_hi_adel", {31'd0, F_AdEL}, 32'd1);
        D_Rs = 32'h6FFC;
        cycle(); chk("jr_top_adel", {31'd0, F_AdEL}, 32'd0);

        // simultaneous exc_req and eret
        idle(); exc_req = 1'b1; eret = 1'b1; EPC = 32'h3100;
        cycle(); chk("exc_eret_pc", F_PC, 32'h0000_4180);
        chk("exc_eret_fl", {31'd0, F_flush}, 32'd1);

        // reset overrides exc_req during stall
        idle(); reset = 1'b0; stall = 1'b1; exc_req = 1'b1;
        cycle(); chk("rst_exc_pc", F_PC, 32'h0000_3000);
        chk("rst_exc_fl", {31'd0, F_flush}, 32'd0);

        // wrap from 0xFFFF_FFFC
        idle(); npc_op = 3'd3; D_Rs = 32'hFFFF_FFFC;
        cycle();
        idle();
        cycle(); chk("wrap_pc", F_PC, 32'h0000_0000);
        chk("wrap_flush", {31'd0, F_flush}, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 49) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            exc_req  = ($urandom_range(0, 15) == 0);
            eret     = ($urandom_range(0, 7) == 0);
            npc_op   = 3'($urandom_range(0, 7));
            br_taken = 1'($urandom_range(0, 1));
            D_PC     = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 16'h3FFF) * 4);
            D_imm16  = 16'($urandom);
            D_imm26  = 26'($urandom);
            D_Rs     = ($urandom_range(0, 3) == 0) ? $urandom : 32'h2FF0 + 32'($urandom_range(0, 16'h4020));
            EPC      = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 16'h3FFF) * 4);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/f_npc_ctrl.md
F_NPC_CTRL -- requirements
Module: f_npc_ctrl

Interface
REQ-001 The block SHALL expose the following ports, one per line: name  direction  width  meaning.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled only on rising clk.
REQ-004 stall  in  1  hazard stall from D stage; holds F_PC.
REQ-005 npc_op  in  3  D-stage transfer kind: 0 sequential, 1 branch, 2 j/jal, 3 jr; 4-7 are treated as 0.
REQ-006 br_taken  in  1  branch-compare result from the D-stage comparator.
REQ-007 D_PC  in  32  PC of the instruction in D.
REQ-008 D_imm16  in  16  branch offset field.
REQ-009 D_imm26  in  26  jump index field.
REQ-010 D_Rs  in  32  forwarded rs value, used as the jr target.
REQ-011 exc_req  in  1  exception or interrupt taken this cycle.
REQ-012 eret  in  1  eret in D, honoured only when stall=0.
REQ-013 EPC  in  32  forwarded EPC value.
REQ-014 F_PC  out  32  fetch address register.
REQ-015 F_BD  out  1  F instruction is in a delay slot; equals (npc_op in 1..3).
REQ-016 F_AdEL  out  1  fetch address error for F_PC.
REQ-017 F_flush  out  1  registered one-cycle pulse; the F instruction is a bubble.

Function
REQ-018 Next-PC priority SHALL be exc_req > (eret & ~stall) > stall > npc_op.
REQ-019 exc_req=1 SHALL load 0x0000_4180 regardless of stall or npc_op.
REQ-020 eret&~stall SHALL load EPC; eret with stall=1 SHALL be ignored and F_PC held.
REQ-021 stall=1 without exc_req SHALL hold F_PC unchanged.
REQ-022 Sequential operation, or npc_op=1 with br_taken=0, SHALL load F_PC+4.
REQ-023 Taken branch SHALL load D_PC+4+(sign_extend(D_imm16)<<2), computed modulo 2^32.
REQ-024 j/jal SHALL load {D_PC[31:28], D_imm26, 2'b00}; jr SHALL load D_Rs unmodified.
REQ-025 Latency SHALL be one cycle: the selected target appears on F_PC after the next rising edge.
REQ-026 F_AdEL SHALL be combinational from F_PC: 1 if F_PC[1:0]!=0, or F_PC<0x0000_3000, or F_PC>0x0000_6FFC.
REQ-027 The PC register SHALL still load a misaligned jr/EPC target; the fault is reported via F_AdEL only.
REQ-028 F_flush SHALL be 1 in the cycle after an accepted exc_req or eret, and 0 otherwise.
REQ-029 Simultaneous exc_req and eret SHALL follow exc_req only, with F_flush=1.
REQ-030 F_PC+4 wrap from 0xFFFF_FFFC SHALL give 0x0000_0000, with no trap.

Reset
REQ-031 reset=0 at a rising edge SHALL set F_PC=0x0000_3000 and F_flush=0, overriding exc_req, eret and stall.
REQ-032 Reset asserted mid-stall or mid-redirect SHALL discard the pending target.
REQ-033 After reset: F_AdEL=0, and F_BD follows its inputs.

Structure
REQ-034 A shared package SHALL hold: PC_RESET=0x0000_3000, EXC_VECTOR=0x0000_4180, IM_LO=0x0000_3000, IM_HI=0x0000_6FFC, and the npc_op encodings NPC_SEQ/NPC_BR/NPC_J/NPC_JR.
REQ-035 One combinational sub-module, f_npc_calc, SHALL compute the target from npc_op/br_taken/D_* fields.
REQ-036 Priority muxing and the registers SHALL stay in f_npc_ctrl.

Verification
REQ-037 Release reset, npc_op=0, stall=0 for 3 cycles -> F_PC 0x3000, 0x3004, 0x3008, 0x300C.
REQ-038 D_PC=0x3010, npc_op=1, br_taken=1, D_imm16=0xFFFC -> F_PC=0x3004, F_BD=1; same with br_taken=0 and F_PC=0x3014 -> F_PC=0x3018.
REQ-039 stall=1 with npc_op=2, exc_req=1 -> F_PC=0x4180, F_flush=1 for exactly one cycle.
REQ-040 eret=1, EPC=0x3020, stall=1 -> F_PC held; next cycle stall=0 -> F_PC=0x3020, F_flush pulse.
REQ-041 npc_op=3, D_Rs=0x3002 -> F_PC=0x3002, F_AdEL=1; D_Rs=0x7000 -> F_AdEL=1; D_Rs=0x6FFC -> F_AdEL=0.
REQ-042 reset=0 asserted together with exc_req=1 during stall -> F_PC=0x3000, F_flush=0.
